// File: rtl/line_mem_responder.sv
// line_mem_responder: shared backing store of 128-bit lines for the I-cache
// and D-cache. It serves one line read at a time with a fixed latency, using
// round-robin arbitration. D-cache write-backs are accepted every cycle and
// can be forwarded into a read captured on the same edge.
module line_mem_responder #(
  parameter int    XLEN           = 32,
  parameter int    LINE_ADDR_BITS = 16,
  parameter int    DEPTH_LINES    = 1024,
  parameter int    LATENCY        = 3,
  parameter string INIT_FILE      = ""
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Ic_mem_req,
  input  logic [LINE_ADDR_BITS-1:0] Ic_mem_addr,
  output logic [127:0]              F_mem_inst,
  output logic                      F_mem_valid,
  input  logic                      Dc_mem_req,
  input  logic [LINE_ADDR_BITS-1:0] Dc_mem_addr,
  output logic [127:0]              MEM_data_line,
  output logic                      MEM_mem_valid,
  input  logic                      Dc_wb_we,
  input  logic [LINE_ADDR_BITS-1:0] Dc_wb_addr,
  input  logic [127:0]              Dc_wb_wline,
  output logic                      Mem_busy
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [127:0] array [0:DEPTH_LINES-1];

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic               sel_d;       // port being served: 1 = D-side
  logic [IDX_W-1:0]   idx;         // latched line index of the read in flight
  logic               last_d;      // last grant went to the D-side
  logic               mask_i, mask_d;

  logic               grant_i, grant_d;
  logic               req_i_ok, req_d_ok;
  logic               sel_next;
  logic [IDX_W-1:0]   cap_idx;
  logic [IDX_W-1:0]   wb_idx;
  logic               capture;
  logic               wb_hit;
  logic               valid_i_next, valid_d_next, busy_next;

  // Upper address bits are intentionally ignored (addresses wrap).
  logic unused_bits;
  assign unused_bits = ^{Ic_mem_addr, Dc_mem_addr, Dc_wb_addr, 32'(XLEN)};

  assign wb_idx   = Dc_wb_addr[IDX_W-1:0];
  assign req_i_ok = Ic_mem_req && !mask_i;
  assign req_d_ok = Dc_mem_req && !mask_d;

  // Next-state logic with round-robin arbitration in IDLE.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_i_ok && req_d_ok) begin
          grant_d = !last_d;
          grant_i = last_d;
        end else begin
          grant_i = req_i_ok;
          grant_d = req_d_ok;
        end
        if (grant_i || grant_d) state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
      end
      S_WAIT:  if (cnt == CNT_W'(1)) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode: which port, which line, and the next registered outputs.
  always_comb begin
    sel_next     = (state == S_IDLE) ? grant_d : sel_d;
    cap_idx      = idx;
    if (state == S_IDLE)
      cap_idx = grant_d ? Dc_mem_addr[IDX_W-1:0] : Ic_mem_addr[IDX_W-1:0];
    // The line is captured on the edge that enters RESP.
    capture      = (state_next == S_RESP) && (state != S_RESP);
    wb_hit       = Dc_wb_we && (wb_idx == cap_idx);
    valid_i_next = (state_next == S_RESP) && !sel_next;
    valid_d_next = (state_next == S_RESP) && sel_next;
    busy_next    = (state_next != S_IDLE);
  end

  // State register plus request bookkeeping (port, index, counter, fairness, mask).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      sel_d  <= 1'b0;
      idx    <= '0;
      last_d <= 1'b1;
      mask_i <= 1'b0;
      mask_d <= 1'b0;
    end else begin
      state  <= state_next;
      // Only the first IDLE cycle after a response masks the port just served.
      mask_i <= (state == S_RESP) && !sel_d;
      mask_d <= (state == S_RESP) && sel_d;
      if (state == S_IDLE && (grant_i || grant_d)) begin
        sel_d  <= grant_d;
        last_d <= grant_d;
        idx    <= cap_idx;
        cnt    <= CNT_W'(LATENCY - 1);
      end else if (state == S_WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Registered outputs; the read line is taken from the array or forwarded from a same-edge write-back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      F_mem_valid   <= 1'b0;
      MEM_mem_valid <= 1'b0;
      Mem_busy      <= 1'b0;
      F_mem_inst    <= '0;
      MEM_data_line <= '0;
    end else begin
      F_mem_valid   <= valid_i_next;
      MEM_mem_valid <= valid_d_next;
      Mem_busy      <= busy_next;
      if (capture && !sel_next)
        F_mem_inst <= wb_hit ? Dc_wb_wline : array[cap_idx];
      if (capture && sel_next)
        MEM_data_line <= wb_hit ? Dc_wb_wline : array[cap_idx];
    end
  end

  // Write-back port; writes during reset are dropped.
  always_ff @(posedge clk) begin
    if (rst && Dc_wb_we) array[wb_idx] <= Dc_wb_wline;
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: a scoreboard holds the expected
// line and response cycle per port; a negedge monitor pops and compares.
module tb_line_mem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         Ic_mem_req;
  logic [15:0]  Ic_mem_addr;
  logic [127:0] F_mem_inst;
  logic         F_mem_valid;
  logic         Dc_mem_req;
  logic [15:0]  Dc_mem_addr;
  logic [127:0] MEM_data_line;
  logic         MEM_mem_valid;
  logic         Dc_wb_we;
  logic [15:0]  Dc_wb_addr;
  logic [127:0] Dc_wb_wline;
  logic         Mem_busy;

  line_mem_responder dut (
    .clk(clk), .rst(rst),
    .Ic_mem_req(Ic_mem_req), .Ic_mem_addr(Ic_mem_addr),
    .F_mem_inst(F_mem_inst), .F_mem_valid(F_mem_valid),
    .Dc_mem_req(Dc_mem_req), .Dc_mem_addr(Dc_mem_addr),
    .MEM_data_line(MEM_data_line), .MEM_mem_valid(MEM_mem_valid),
    .Dc_wb_we(Dc_wb_we), .Dc_wb_addr(Dc_wb_addr), .Dc_wb_wline(Dc_wb_wline),
    .Mem_busy(Mem_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [127:0] line;
    int           cyc;
  } exp_t;

  exp_t q_i[$];
  exp_t q_d[$];
  exp_t ei, ed;

  // Scoreboard monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (F_mem_valid === 1'b1) begin
      if (q_i.size() == 0) begin
        check("i_spurious", 128'd1, 128'd0);
      end else begin
        ei = q_i.pop_front();
        $display("I resp cyc=%0d line=%h", cyc, F_mem_inst);
        check("i_line", F_mem_inst, ei.line);
        check("i_cyc", 128'(cyc), 128'(ei.cyc));
      end
    end
    if (MEM_mem_valid === 1'b1) begin
      if (q_d.size() == 0) begin
        check("d_spurious", 128'd1, 128'd0);
      end else begin
        ed = q_d.pop_front();
        $display("D resp cyc=%0d line=%h", cyc, MEM_data_line);
        check("d_line", MEM_data_line, ed.line);
        check("d_cyc", 128'(cyc), 128'(ed.cyc));
      end
    end
  end

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_fvalid"}, 128'(F_mem_valid), 128'd0);
    check({tag, "_dvalid"}, 128'(MEM_mem_valid), 128'd0);
    check({tag, "_busy"}, 128'(Mem_busy), 128'd0);
    check({tag, "_finst"}, F_mem_inst, 128'd0);
    check({tag, "_dline"}, MEM_data_line, 128'd0);
  endtask

  localparam logic [127:0] L2  = {4{32'h2222_0002}};
  localparam logic [127:0] L5  = {16{8'hA5}};
  localparam logic [127:0] L7  = {4{32'h7777_0007}};
  localparam logic [127:0] L9  = {4{32'h9999_0009}};
  localparam logic [127:0] L3  = {4{32'h3333_0003}};
  localparam logic [127:0] BAD = {4{32'hDEAD_BEEF}};
  localparam logic [127:0] WR  = {4{32'h0403_CAFE}};

  int           pre_addr [5];
  logic [127:0] pre_line [5];
  int           c0;
  int           cr;

  initial begin
    pre_addr = '{2, 5, 7, 9, 3};
    pre_line = '{L2, L5, L7, L9, L3};
    rst = 1'b0;
    Ic_mem_req = 1'b0; Ic_mem_addr = '0;
    Dc_mem_req = 1'b0; Dc_mem_addr = '0;
    Dc_wb_we = 1'b0; Dc_wb_addr = '0; Dc_wb_wline = '0;

    // Power-on reset
    goto(3);
    @(negedge clk);
    chk_zero("reset");
    goto(4);
    rst = 1'b1;

    // Preload lines through the write-back port
    for (int i = 0; i < 5; i++) begin
      Dc_wb_we = 1'b1; Dc_wb_addr = 16'(pre_addr[i]); Dc_wb_wline = pre_line[i];
      @(posedge clk); #1;
    end
    Dc_wb_we = 1'b0;

    // Single I read of line 5, request held one cycle past valid
    c0 = cyc + 2;
    goto(c0);
    Ic_mem_req = 1'b1; Ic_mem_addr = 16'd5;
    q_i.push_back('{L5, c0 + 3});
    @(negedge clk); check("busy_c0", 128'(Mem_busy), 128'd0);
    goto(c0 + 1); @(negedge clk); check("busy_c1", 128'(Mem_busy), 128'd1);
    goto(c0 + 3); @(negedge clk); check("busy_c3", 128'(Mem_busy), 128'd1);
    goto(c0 + 4); @(negedge clk); check("busy_c4", 128'(Mem_busy), 128'd0);
    goto(c0 + 5);
    Ic_mem_req = 1'b0;
    goto(c0 + 10);
    @(negedge clk); check("i_hold", F_mem_inst, L5);

    // Reset during an active D read; a write-back inside reset is dropped
    c0 = cyc + 1;
    goto(c0);
    Dc_mem_req = 1'b1; Dc_mem_addr = 16'd7;
    goto(c0 + 1);
    rst = 1'b0;
    goto(c0 + 2);
    Dc_wb_we = 1'b1; Dc_wb_addr = 16'd5; Dc_wb_wline = BAD;
    @(negedge clk); chk_zero("rst_mid");
    goto(c0 + 3);
    Dc_wb_we = 1'b0;
    @(negedge clk); chk_zero("rst_rel");
    // Release with both ports requesting: I first, then D
    rst = 1'b1;
    cr = c0 + 3;
    Ic_mem_req = 1'b1; Ic_mem_addr = 16'd2;
    q_i.push_back('{L2, cr + 3});
    q_d.push_back('{L7, cr + 7});
    goto(cr + 4);
    Ic_mem_req = 1'b0;
    goto(cr + 8);
    Dc_mem_req = 1'b0;
    Ic_mem_req = 1'b1; Ic_mem_addr = 16'd5;
    q_i.push_back('{L5, cr + 11});
    goto(cr + 12);
    Ic_mem_req = 1'b0;
    goto(cr + 16);

    // Write-back in the capture cycle is forwarded
    c0 = cyc;
    Dc_mem_req = 1'b1; Dc_mem_addr = 16'd9;
    q_d.push_back('{128'h1234, c0 + 3});
    goto(c0 + 2);
    Dc_wb_we = 1'b1; Dc_wb_addr = 16'd9; Dc_wb_wline = 128'h1234;
    goto(c0 + 3);
    Dc_wb_we = 1'b0;
    goto(c0 + 4);
    Dc_mem_req = 1'b0;
    goto(c0 + 8);

    // Write-back one cycle after capture does not affect the response
    c0 = cyc;
    Dc_mem_req = 1'b1; Dc_mem_addr = 16'd9;
    q_d.push_back('{128'h1234, c0 + 3});
    goto(c0 + 3);
    Dc_wb_we = 1'b1; Dc_wb_addr = 16'd9; Dc_wb_wline = 128'h5678;
    goto(c0 + 4);
    Dc_wb_we = 1'b0;
    Dc_mem_req = 1'b0;
    goto(c0 + 8);

    // The later write did land in the array
    c0 = cyc;
    Ic_mem_req = 1'b1; Ic_mem_addr = 16'd9;
    q_i.push_back('{128'h5678, c0 + 3});
    goto(c0 + 4);
    Ic_mem_req = 1'b0;
    goto(c0 + 8);

    // Address wrap modulo the array depth
    Dc_wb_we = 1'b1; Dc_wb_addr = 16'h0403; Dc_wb_wline = WR;
    goto(cyc + 1);
    Dc_wb_we = 1'b0;
    c0 = cyc;
    Dc_mem_req = 1'b1; Dc_mem_addr = 16'h0003;
    q_d.push_back('{WR, c0 + 3});
    goto(c0 + 4);
    Dc_mem_req = 1'b0;
    goto(c0 + 10);

    check("i_drained", 128'(q_i.size()), 128'd0);
    check("d_drained", 128'(q_d.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
